handle_bus_ctrl: RTL and testbench

Sequencer between the CPU/load-store side and the object_cell array's shared handle bus. It accepts translate, allocate and free requests over a valid/ready handshake. It drives the cell command lines (cs, read_address, get_available_id, write_to_map, write_invalid) and the bus data, and returns a translated physical address, a new handle address, or a fault. It keeps a shadow valid bitmap of all 2^HNDL_WIDTH handles so that faults are detected without bus traffic.

---
 rtl/hamory_pkg.sv | 48 ++++
 rtl/handle_bitmap.sv | 51 +++++
 rtl/handle_bus_ctrl.sv | 174 +++++++++++++++++
 tb/tb_handle_bus_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hamory_pkg.sv
// Shared widths, encodings and handle-address helpers for the handle bus sequencer.
package hamory_pkg;

    localparam int ADDR_WIDTH  = 64;
    localparam int HNDL_WIDTH  = 8;
    localparam int OFF_WIDTH   = ADDR_WIDTH - HNDL_WIDTH - 1;
    localparam int NUM_HANDLES = 1 << HNDL_WIDTH;

    typedef enum logic [1:0] {
        OP_TRANSLATE = 2'd0,
        OP_ALLOC     = 2'd1,
        OP_FREE      = 2'd2,
        OP_RESERVED  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        FAULT_NONE      = 2'd0,
        FAULT_UNMAPPED  = 2'd1,
        FAULT_NO_FREE   = 2'd2,
        FAULT_COHERENCY = 2'd3
    } fault_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_ALLOC_ID,
        S_ALLOC_MAP,
        S_FREE,
        S_RESP
    } state_e;

    function automatic logic addr_is_handle(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1];
    endfunction

    function automatic logic [HNDL_WIDTH-1:0] addr_hndl(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-2:OFF_WIDTH];
    endfunction

    function automatic logic [OFF_WIDTH-1:0] addr_off(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFF_WIDTH-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] make_handle_addr(input logic [HNDL_WIDTH-1:0] id);
        return {1'b1, id, {OFF_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/handle_bitmap.sv
// Shadow valid bit per handle, with a registered full flag kept by a population counter.
module handle_bitmap
    import hamory_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [HNDL_WIDTH-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [HNDL_WIDTH-1:0] clr_idx,
    input  logic [HNDL_WIDTH-1:0] rd_idx,
    output logic                  rd_valid,
    output logic                  full
);

    localparam logic [HNDL_WIDTH:0] CNT_ONE  = (HNDL_WIDTH+1)'(1);
    localparam logic [HNDL_WIDTH:0] CNT_FULL = (HNDL_WIDTH+1)'(NUM_HANDLES);

    logic [NUM_HANDLES-1:0] valid_bits;
    logic [HNDL_WIDTH:0]    count;
    logic [HNDL_WIDTH:0]    count_next;
    logic                   set_eff;
    logic                   clr_eff;

    assign rd_valid = valid_bits[rd_idx];

    // Only real bit transitions move the counter, so it always matches the bitmap.
    always_comb begin
        // NOTE: every always_comb output gets a value before any condition, so no latch is inferred.
        set_eff    = set_en && !valid_bits[set_idx];
        clr_eff    = clr_en && valid_bits[clr_idx];
        count_next = count;
        if (set_eff) count_next = count_next + CNT_ONE;
        if (clr_eff) count_next = count_next - CNT_ONE;
    end

    // NOTE: the bitmap is plain flops, so it is reset like any register; a RAM could not be cleared this way.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_bits <= '0;
            count      <= '0;
            full       <= 1'b0;
        end else begin
            if (set_eff) valid_bits[set_idx] <= 1'b1;
            if (clr_eff) valid_bits[clr_idx] <= 1'b0;
            count <= count_next;
            full  <= (count_next == CNT_FULL);
        end
    end

endmodule

// File: rtl/handle_bus_ctrl.sv
// Sequences translate/alloc/free requests onto the shared object_cell handle bus.
module handle_bus_ctrl
    import hamory_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [1:0]            resp_fault,
    output logic [HNDL_WIDTH-1:0] cs,
    output logic                  read_address,
    output logic                  get_available_id,
    output logic                  write_to_map,
    output logic                  write_invalid,
    output logic [OFF_WIDTH-1:0]  bus_out,
    output logic                  bus_oe,
    input  logic [OFF_WIDTH-1:0]  bus_in
);

    state_e                state;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [HNDL_WIDTH-1:0] req_hndl;
    logic [HNDL_WIDTH-1:0] bus_id;
    logic [HNDL_WIDTH-1:0] bm_rd_idx;
    logic [OFF_WIDTH-1:0]  lookup_sum;
    logic                  bm_rd_valid;
    logic                  bm_full;

    assign req_hndl   = addr_hndl(req_addr);
    assign bus_id     = bus_in[HNDL_WIDTH-1:0];
    // Carry out of the offset add is dropped: translated addresses wrap inside the mapped window.
    assign lookup_sum = bus_in + addr_off(cap_addr);
    // The single bitmap read port checks the incoming handle in IDLE and the offered id in ALLOC_ID.
    assign bm_rd_idx  = (state == S_ALLOC_ID) ? bus_id : req_hndl;

    handle_bitmap u_bitmap (
        .clock    (clock),
        .reset    (reset),
        .set_en   (state == S_ALLOC_MAP),
        .set_idx  (cs),
        .clr_en   (state == S_FREE),
        .clr_idx  (cs),
        .rd_idx   (bm_rd_idx),
        .rd_valid (bm_rd_valid),
        .full     (bm_full)
    );

    // Every bus command is a flop, so levels are glitch-free and reset drops them asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: state and outputs use non-blocking assignments so all flops update together at the edge.
            state            <= S_IDLE;
            req_ready        <= 1'b0;
            resp_valid       <= 1'b0;
            resp_addr        <= '0;
            resp_fault       <= FAULT_NONE;
            cs               <= '0;
            read_address     <= 1'b0;
            get_available_id <= 1'b0;
            write_to_map     <= 1'b0;
            write_invalid    <= 1'b0;
            bus_out          <= '0;
            bus_oe           <= 1'b0;
            cap_addr         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        cap_addr   <= req_addr;
                        resp_addr  <= '0;
                        resp_fault <= FAULT_NONE;
                        case (op_e'(req_op))
                            OP_TRANSLATE: begin
                                if (!addr_is_handle(req_addr)) begin
                                    resp_addr  <= req_addr;
                                    resp_valid <= 1'b1;
                                    state      <= S_RESP;
                                end else if (!bm_rd_valid) begin
                                    resp_fault <= FAULT_UNMAPPED;
                                    resp_valid <= 1'b1;
                                    state      <= S_RESP;
                                end else begin
                                    cs           <= req_hndl;
                                    read_address <= 1'b1;
                                    state        <= S_LOOKUP;
                                end
                            end
                            OP_ALLOC: begin
                                if (bm_full) begin
                                    resp_fault <= FAULT_NO_FREE;
                                    resp_valid <= 1'b1;
                                    state      <= S_RESP;
                                end else begin
                                    get_available_id <= 1'b1;
                                    state            <= S_ALLOC_ID;
                                end
                            end
                            OP_FREE: begin
                                if (!addr_is_handle(req_addr) || !bm_rd_valid) begin
                                    resp_fault <= FAULT_COHERENCY;
                                    resp_valid <= 1'b1;
                                    state      <= S_RESP;
                                end else begin
                                    cs            <= req_hndl;
                                    write_invalid <= 1'b1;
                                    state         <= S_FREE;
                                end
                            end
                            default: begin
                                resp_fault <= FAULT_COHERENCY;
                                resp_valid <= 1'b1;
                                state      <= S_RESP;
                            end
                        endcase
                    end
                end
                S_LOOKUP: begin
                    read_address <= 1'b0;
                    cs           <= '0;
                    resp_addr    <= {{(HNDL_WIDTH+1){1'b0}}, lookup_sum};
                    resp_valid   <= 1'b1;
                    state        <= S_RESP;
                end
                S_ALLOC_ID: begin
                    get_available_id <= 1'b0;
                    // A cell offering an id the shadow already holds means cells and shadow disagree.
                    if (bm_rd_valid) begin
                        resp_fault <= FAULT_COHERENCY;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        cs           <= bus_id;
                        write_to_map <= 1'b1;
                        bus_oe       <= 1'b1;
                        bus_out      <= addr_off(cap_addr);
                        state        <= S_ALLOC_MAP;
                    end
                end
                S_ALLOC_MAP: begin
                    write_to_map <= 1'b0;
                    bus_oe       <= 1'b0;
                    bus_out      <= '0;
                    cs           <= '0;
                    resp_addr    <= make_handle_addr(cs);
                    resp_valid   <= 1'b1;
                    state        <= S_RESP;
                end
                S_FREE: begin
                    write_invalid <= 1'b0;
                    cs            <= '0;
                    resp_addr     <= cap_addr;
                    resp_valid    <= 1'b1;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_handle_bus_ctrl.sv
// Directed bench for handle_bus_ctrl; the bench plays the cell array by setting bus_in per step.
module tb_handle_bus_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [63:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_addr;
    logic [1:0]  resp_fault;
    logic [7:0]  cs;
    logic        read_address;
    logic        get_available_id;
    logic        write_to_map;
    logic        write_invalid;
    logic [54:0] bus_out;
    logic        bus_oe;
    logic [54:0] bus_in = '1;

    int checks = 0;
    int errors = 0;

    // Command activity seen by the cells, sampled on the falling edge where they commit.
    int          gid_cnt = 0, rd_cnt = 0, wmap_cnt = 0, winv_cnt = 0;
    logic [7:0]  rd_cs = '0, wmap_cs = '0, winv_cs = '0;
    logic [54:0] wmap_bus = '0;
    logic        wmap_oe = 1'b0;

    handle_bus_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_addr        (resp_addr),
        .resp_fault       (resp_fault),
        .cs               (cs),
        .read_address     (read_address),
        .get_available_id (get_available_id),
        .write_to_map     (write_to_map),
        .write_invalid    (write_invalid),
        .bus_out          (bus_out),
        .bus_oe           (bus_oe),
        .bus_in           (bus_in)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (get_available_id) gid_cnt <= gid_cnt + 1;
        if (read_address) begin
            rd_cnt <= rd_cnt + 1;
            rd_cs  <= cs;
        end
        if (write_to_map) begin
            wmap_cnt <= wmap_cnt + 1;
            wmap_cs  <= cs;
            wmap_bus <= bus_out;
            wmap_oe  <= bus_oe;
        end
        if (write_invalid) begin
            winv_cnt <= winv_cnt + 1;
            winv_cs  <= cs;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request (entered just after a rising edge), check latency, optionally hold the response.
    task automatic do_req(input string tag, input logic [1:0] op, input logic [63:0] addr,
                          input int exp_lat, input int hold,
                          output logic [1:0] f, output logic [63:0] ra);
        int   n;
        int   lat;
        logic stable;
        n = 0;
        while (!req_ready && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, "_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        f  = resp_fault;
        ra = resp_addr;
        if (hold > 0) begin
            stable = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(posedge clock); #1;
                if (!resp_valid || resp_addr !== ra || resp_fault !== f || req_ready) stable = 1'b0;
            end
            check({tag, "_hold_stable"}, stable, 1'b1);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    logic [1:0]  f;
    logic [63:0] ra;
    int          g0, r0, m0, w0, nf;

    initial begin
        // Reset state, checked while reset is held.
        #12;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_addr", resp_addr, 64'h0);
        check("rst_cmds", {cs, read_address, get_available_id, write_to_map, write_invalid, bus_oe}, 0);
        check("rst_bus_out", bus_out, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("ready_after_reset", req_ready, 1'b1);

        // Plain address passes straight through.
        g0 = gid_cnt; r0 = rd_cnt; m0 = wmap_cnt; w0 = winv_cnt;
        do_req("tr_plain", 2'd0, 64'h0000_0000_1234_5678, 1, 0, f, ra);
        check("tr_plain_addr", ra, 64'h0000_0000_1234_5678);
        check("tr_plain_fault", f, 2'd0);
        check("tr_plain_no_cmd", 64'(gid_cnt - g0 + rd_cnt - r0 + wmap_cnt - m0 + winv_cnt - w0), 0);

        // Allocate base 0x1000; cells offer id 5.
        bus_in = 55'h05;
        g0 = gid_cnt; m0 = wmap_cnt;
        do_req("alloc5", 2'd1, 64'h1000, 3, 0, f, ra);
        check("alloc5_gid_cycles", 64'(gid_cnt - g0), 1);
        check("alloc5_map_cycles", 64'(wmap_cnt - m0), 1);
        check("alloc5_map_cs", wmap_cs, 8'h05);
        check("alloc5_map_bus", wmap_bus, 55'h1000);
        check("alloc5_map_oe", wmap_oe, 1'b1);
        check("alloc5_addr", ra, {1'b1, 8'h05, 55'h0});
        check("alloc5_fault", f, 2'd0);

        // Translate handle 5 offset 0x20 against base 0x1000.
        bus_in = 55'h1000;
        r0 = rd_cnt;
        do_req("tr_h5", 2'd0, {1'b1, 8'h05, 55'h20}, 2, 0, f, ra);
        check("tr_h5_rd_cycles", 64'(rd_cnt - r0), 1);
        check("tr_h5_rd_cs", rd_cs, 8'h05);
        check("tr_h5_addr", ra, 64'h1020);
        check("tr_h5_fault", f, 2'd0);

        // Offset all ones plus base 1 wraps to zero.
        bus_in = 55'h1;
        do_req("tr_wrap", 2'd0, {1'b1, 8'h05, 55'h7F_FFFF_FFFF_FFFF}, 2, 0, f, ra);
        check("tr_wrap_addr", ra, 64'h0);
        check("tr_wrap_fault", f, 2'd0);

        // Cells offer id 5 again while it is mapped: coherency fault, no map write.
        bus_in = 55'h05;
        g0 = gid_cnt; m0 = wmap_cnt;
        do_req("alloc_dup", 2'd1, 64'h2000, 2, 0, f, ra);
        check("alloc_dup_fault", f, 2'd3);
        check("alloc_dup_gid", 64'(gid_cnt - g0), 1);
        check("alloc_dup_no_map", 64'(wmap_cnt - m0), 0);

        // Free handle 5, then free it again.
        bus_in = '1;
        w0 = winv_cnt;
        do_req("free5", 2'd2, {1'b1, 8'h05, 55'h0}, 2, 0, f, ra);
        check("free5_inv_cycles", 64'(winv_cnt - w0), 1);
        check("free5_inv_cs", winv_cs, 8'h05);
        check("free5_fault", f, 2'd0);
        check("free5_addr", ra, {1'b1, 8'h05, 55'h0});
        w0 = winv_cnt;
        do_req("free5_again", 2'd2, {1'b1, 8'h05, 55'h0}, 1, 0, f, ra);
        check("free5_again_fault", f, 2'd3);
        check("free5_again_no_inv", 64'(winv_cnt - w0), 0);

        // Freed handle no longer translates, and no read goes to the cells.
        r0 = rd_cnt;
        do_req("tr_freed", 2'd0, {1'b1, 8'h05, 55'h20}, 1, 0, f, ra);
        check("tr_freed_fault", f, 2'd1);
        check("tr_freed_addr", ra, 64'h0);
        check("tr_freed_no_rd", 64'(rd_cnt - r0), 0);

        do_req("reserved_op", 2'd3, 64'h0, 1, 0, f, ra);
        check("reserved_fault", f, 2'd3);

        // Reset asserted in ALLOC_MAP drops the map write and bus drive without a clock edge.
        bus_in    = 55'h07;
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_addr  = 64'h3000;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        check("mid_map_before", write_to_map, 1'b1);
        check("mid_oe_before", bus_oe, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_map_after_rst", write_to_map, 1'b0);
        check("mid_oe_after_rst", bus_oe, 1'b0);
        check("mid_cs_after_rst", cs, 8'h00);
        @(negedge clock);
        @(negedge clock);
        reset  = 1'b0;
        bus_in = '1;
        @(posedge clock); #1;
        do_req("tr_after_rst", 2'd0, {1'b1, 8'h07, 55'h0}, 1, 0, f, ra);
        check("tr_after_rst_fault", f, 2'd1);

        // Fill every handle, then one more allocation must fault without searching.
        nf = 0;
        for (int i = 0; i < 256; i++) begin
            bus_in = 55'(i);
            do_req("fill", 2'd1, 64'(i), 3, 0, f, ra);
            if (f != 2'd0) nf++;
        end
        check("fill_faults", 64'(nf), 0);
        check("fill_last_addr", ra, {1'b1, 8'hFF, 55'h0});
        bus_in = '0;
        g0 = gid_cnt;
        do_req("alloc_full", 2'd1, 64'h4000, 1, 5, f, ra);
        check("alloc_full_fault", f, 2'd2);
        check("alloc_full_addr", ra, 64'h0);
        check("alloc_full_no_gid", 64'(gid_cnt - g0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
